// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between fetch (alloc), execute (resolve) and the predictor (update/redirect).
// slave is the queue side; master is the side that drives alloc/resolve.
interface branch_resolve_queue_if #(
  parameter int TAG_BITS = 3,
  parameter int IDX_BITS = 5
);
  logic                alloc_valid;
  logic [31:0]         alloc_pc;
  logic [IDX_BITS-1:0] alloc_pht_index;
  logic                alloc_pred;
  logic                alloc_ready;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                resolve_valid;
  logic [TAG_BITS-1:0] resolve_tag;
  logic                resolve_taken;
  logic [31:0]         resolve_target;
  logic                upd_valid;
  logic [IDX_BITS-1:0] upd_pht_index;
  logic                upd_result;
  logic                mispredict;
  logic [31:0]         mispredict_pc;
  logic [TAG_BITS:0]   count;

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pht_index, alloc_pred,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag,
    output upd_valid, upd_pht_index, upd_result, mispredict, mispredict_pc, count
  );

  modport master (
    output alloc_valid, alloc_pc, alloc_pht_index, alloc_pred,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag,
    input  upd_valid, upd_pht_index, upd_result, mispredict, mispredict_pc, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue: out-of-order resolve by tag, in-order retire with
// PHT training updates, and a full flush when a retiring branch was mispredicted.
module branch_resolve_queue #(
  parameter int TAG_BITS = 3,
  parameter int IDX_BITS = 5
) (
  input logic                  clock,
  input logic                  reset,
  branch_resolve_queue_if.slave bus
);
  localparam int DEPTH = 1 << TAG_BITS;
  localparam logic [TAG_BITS:0] FULL = (TAG_BITS + 1)'(DEPTH);

  logic [DEPTH-1:0]    valid_q, resolved_q, pred_q, taken_q;
  logic [IDX_BITS-1:0] idx_q    [DEPTH];
  logic [31:0]         pc_q     [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic [TAG_BITS-1:0] head, tail;
  logic [TAG_BITS:0]   count_q;

  logic                upd_valid_q, upd_result_q, mispredict_q;
  logic [IDX_BITS-1:0] upd_idx_q;
  logic [31:0]         mispredict_pc_q;

  logic retire, flush, alloc_acc, resolve_acc;

  assign retire      = valid_q[head] & resolved_q[head];
  assign flush       = retire & (taken_q[head] != pred_q[head]);
  assign alloc_acc   = bus.alloc_valid & bus.alloc_ready & ~flush;
  assign resolve_acc = bus.resolve_valid & valid_q[bus.resolve_tag] & ~flush;

  assign bus.alloc_ready   = count_q < FULL;
  assign bus.alloc_tag     = tail;
  assign bus.count         = count_q;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_pht_index = upd_idx_q;
  assign bus.upd_result    = upd_result_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.mispredict_pc = mispredict_pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i]    <= '0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (resolve_acc) begin
        resolved_q[bus.resolve_tag] <= 1'b1;
        taken_q[bus.resolve_tag]    <= bus.resolve_taken;
        target_q[bus.resolve_tag]   <= bus.resolve_target;
      end
      // Retire clear comes after resolve so a re-resolve of the retiring head cannot revive it.
      if (retire) begin
        valid_q[head]    <= 1'b0;
        resolved_q[head] <= 1'b0;
      end
      // tail never equals a valid slot while alloc_ready is high.
      if (alloc_acc) begin
        valid_q[tail]    <= 1'b1;
        resolved_q[tail] <= 1'b0;
        pred_q[tail]     <= bus.alloc_pred;
        idx_q[tail]      <= bus.alloc_pht_index;
        pc_q[tail]       <= bus.alloc_pc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= head + 1'b1;
      tail    <= head + 1'b1;
      count_q <= '0;
    end else begin
      if (retire)    head <= head + 1'b1;
      if (alloc_acc) tail <= tail + 1'b1;
      case ({alloc_acc, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upd_valid_q     <= 1'b0;
      upd_idx_q       <= '0;
      upd_result_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
    end else begin
      upd_valid_q  <= retire;
      mispredict_q <= flush;
      if (retire) begin
        upd_idx_q    <= idx_q[head];
        upd_result_q <= taken_q[head];
      end
      if (flush)
        mispredict_pc_q <= taken_q[head] ? target_q[head] : pc_q[head] + 32'd4;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and randomized checks of branch_resolve_queue against a queue-based program-order model.
module tb_branch_resolve_queue;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  branch_resolve_queue_if #(.TAG_BITS(3), .IDX_BITS(5)) bus ();

  branch_resolve_queue #(.TAG_BITS(3), .IDX_BITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  idx;
    logic        pred;
    logic [31:0] pc;
    logic        res;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  m_tag;
  logic        m_uv, m_ures, m_mp;
  logic [4:0]  m_uidx;
  logic [31:0] m_mpc;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.alloc_valid     = 1'b0;
    bus.alloc_pc        = '0;
    bus.alloc_pht_index = '0;
    bus.alloc_pred      = 1'b0;
    bus.resolve_valid   = 1'b0;
    bus.resolve_tag     = '0;
    bus.resolve_taken   = 1'b0;
    bus.resolve_target  = '0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] idx, input logic pred);
    bus.alloc_valid     = 1'b1;
    bus.alloc_pc        = pc;
    bus.alloc_pht_index = idx;
    bus.alloc_pred      = pred;
  endtask

  task automatic set_res(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    bus.resolve_valid  = 1'b1;
    bus.resolve_tag    = tag;
    bus.resolve_taken  = taken;
    bus.resolve_target = tgt;
  endtask

  task automatic check_outputs();
    chk("count",         32'(bus.count),         32'(q.size()));
    chk("alloc_ready",   32'(bus.alloc_ready),   32'(q.size() < 8));
    chk("alloc_tag",     32'(bus.alloc_tag),     32'(m_tag));
    chk("upd_valid",     32'(bus.upd_valid),     32'(m_uv));
    chk("upd_pht_index", 32'(bus.upd_pht_index), 32'(m_uidx));
    chk("upd_result",    32'(bus.upd_result),    32'(m_ures));
    chk("mispredict",    32'(bus.mispredict),    32'(m_mp));
    chk("mispredict_pc", bus.mispredict_pc,      m_mpc);
  endtask

  // Advance one clock: update the model from the presented inputs, then compare after the edge.
  task automatic step();
    ent_t e;
    bit   ret, fl;
    int   n;
    n   = q.size();
    ret = (n > 0) && q[0].res;
    fl  = ret && (q[0].tk != q[0].pred);
    m_uv = ret;
    m_mp = fl;
    if (ret) begin
      m_uidx = q[0].idx;
      m_ures = q[0].tk;
    end
    if (fl) begin
      m_mpc = q[0].tk ? q[0].tgt : q[0].pc + 32'd4;
      m_tag = q[0].tag + 3'd1;
      q.delete();
    end else begin
      if (bus.resolve_valid)
        for (int i = 0; i < n; i++)
          if (q[i].tag == bus.resolve_tag && !(ret && i == 0)) begin
            q[i].res = 1'b1;
            q[i].tk  = bus.resolve_taken;
            q[i].tgt = bus.resolve_target;
          end
      if (bus.alloc_valid && n < 8) begin
        e.tag  = m_tag;
        e.idx  = bus.alloc_pht_index;
        e.pred = bus.alloc_pred;
        e.pc   = bus.alloc_pc;
        e.res  = 1'b0;
        e.tk   = 1'b0;
        e.tgt  = '0;
        q.push_back(e);
        m_tag = m_tag + 3'd1;
      end
      if (ret) void'(q.pop_front());
    end
    @(posedge clock);
    #1;
    check_outputs();
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rst_count",       32'(bus.count),       32'd0);
    chk("rst_upd_valid",   32'(bus.upd_valid),   32'd0);
    chk("rst_mispredict",  32'(bus.mispredict),  32'd0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_tag",   32'(bus.alloc_tag),   32'd0);
    q.delete();
    m_tag = '0; m_uv = 1'b0; m_uidx = '0; m_ures = 1'b0; m_mp = 1'b0; m_mpc = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int i;
    clear_inputs();
    do_reset();
    chk("rst_mispredict_pc", bus.mispredict_pc, 32'd0);

    // In-order resolve, all correct predictions
    set_alloc(32'h1000, 5'd5, 1'b1);  step();
    set_alloc(32'h1010, 5'd9, 1'b0);  step();
    set_alloc(32'h1020, 5'd17, 1'b1); step();
    set_res(3'd0, 1'b1, 32'h2000); step();
    set_res(3'd1, 1'b0, 32'h0);    step();
    set_res(3'd2, 1'b1, 32'h3000); step();
    repeat (3) step();
    chk("t1_final_count", 32'(bus.count), 32'd0);

    // Fill to full, ninth alloc ignored
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_alloc(32'h100 + 32'(k * 4), 5'(k), 1'b0);
      step();
    end
    chk("full_count", 32'(bus.count), 32'd8);
    set_alloc(32'h900, 5'd31, 1'b0); step();
    chk("full_ignored_tag", 32'(bus.alloc_tag), 32'd0);
    set_res(3'd0, 1'b0, 32'h0); step();
    step();
    chk("full_ready_after_retire", 32'(bus.alloc_ready), 32'd1);

    // Out-of-order resolution
    do_reset();
    set_alloc(32'h40, 5'd1, 1'b0); step();
    set_alloc(32'h44, 5'd2, 1'b1); step();
    set_alloc(32'h48, 5'd3, 1'b0); step();
    set_res(3'd2, 1'b0, 32'h0);   step();
    set_res(3'd1, 1'b1, 32'h500); step();
    set_res(3'd0, 1'b0, 32'h0);   step();
    repeat (4) step();

    // Taken mispredict with a same-cycle alloc that must be dropped
    do_reset();
    set_alloc(32'h40, 5'd7, 1'b0);  step();
    set_alloc(32'h44, 5'd8, 1'b0);  step();
    set_alloc(32'h48, 5'd9, 1'b1);  step();
    set_res(3'd0, 1'b1, 32'h100);   step();
    set_alloc(32'h4c, 5'd10, 1'b0); step();
    chk("mp_pulse", 32'(bus.mispredict), 32'd1);
    chk("mp_pc", bus.mispredict_pc, 32'h100);
    chk("mp_count", 32'(bus.count), 32'd0);
    chk("mp_next_tag", 32'(bus.alloc_tag), 32'd1);
    step();

    // Not-taken mispredict with PC wrap
    do_reset();
    set_alloc(32'hFFFF_FFFC, 5'd3, 1'b1); step();
    set_res(3'd0, 1'b0, 32'h0); step();
    step();
    chk("nt_mp_pc_wrap", bus.mispredict_pc, 32'h0);
    step();

    // Wrap: tags cycle through 0..7 more than twice
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic p;
      p = 1'($urandom);
      set_alloc($urandom, 5'($urandom), p); step();
      set_res(m_tag - 3'd1, p, $urandom);   step();
      step();
    end
    for (int k = 0; k < 4; k++) begin
      set_alloc($urandom, 5'($urandom), 1'b0);
      step();
    end
    set_res(q[0].tag, 1'b0, 32'h0);
    set_res(q[1].tag, 1'b0, 32'h0);
    step();
    set_res(q[1].tag, 1'b0, 32'h0);
    #2;
    do_reset();
    repeat (4) step();

    // Randomized mix
    for (i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 6)
        set_alloc($urandom, 5'($urandom), 1'($urandom));
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        int j;
        j = $urandom_range(0, q.size() - 1);
        set_res(q[j].tag, ($urandom_range(0, 9) < 8) ? q[j].pred : ~q[j].pred, $urandom);
      end else if ($urandom_range(0, 9) < 2) begin
        set_res(3'($urandom), 1'($urandom), $urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
